// File: rtl/cap_sense_pkg.sv
// cap_sense_pkg: shared constants for the capacitive-sensor scanner.
//   - FSM state encodings (IDLE / DISCHARGE / CHARGE / EVAL)
//   - default sensor count and charge-counter width
//   - calibration scan count used when CAP_SENSE_BASELINE_EN is defined
package cap_sense_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_DISCHARGE = 2'd1;
  localparam logic [1:0] ST_CHARGE    = 2'd2;
  localparam logic [1:0] ST_EVAL      = 2'd3;

  localparam int N_SENSORS_DEF = 9;
  localparam int CNT_W_DEF     = 16;

  // Number of scans averaged into the baseline; must stay a power of two
  // because the average is taken with a right shift by CAL_SHIFT.
  localparam int CAL_SCANS = 8;
  localparam int CAL_SHIFT = 3;

endpackage

// File: rtl/cap_sense_channel.sv
// cap_sense_channel: one capacitive pad measurement channel.
//   Synchronizes the raw pad input, counts charge cycles until the pad reads
//   high (saturating at TIMEOUT), compares the count against the threshold at
//   the end of each scan and debounces the result into the touched bit.
// Optional build macro: CAP_SENSE_BASELINE_EN adds a per-channel baseline
//   accumulator; the threshold then becomes relative to that baseline.
// Ports:
//   clock, reset   : system clock, synchronous active-high reset
//   pad_in         : raw asynchronous pad input
//   clr_charge     : clear count/done at the start of a charge phase
//   charge_en      : high for every cycle of the charge phase
//   eval_en        : high for the single evaluation cycle
//   cal_active     : (baseline build only) scan is a calibration scan
//   done_nxt       : next-cycle done flag, used by the FSM for early exit
//   touched        : debounced touch state
//   touched_rise   : touched is about to go 0->1 on the next edge
module cap_sense_channel
  import cap_sense_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int TIMEOUT        = 4095,
  parameter int THRESHOLD      = 400,
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic pad_in,
  input  logic clr_charge,
  input  logic charge_en,
  input  logic eval_en,
`ifdef CAP_SENSE_BASELINE_EN
  input  logic cal_active,
`endif
  output logic done_nxt,
  output logic touched,
  output logic touched_rise
);

  localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] THRESHOLD_C = CNT_W'(THRESHOLD);
  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_SCANS - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic             touched_q, touched_d;
  logic             raw;
  logic             deb_en;

`ifdef CAP_SENSE_BASELINE_EN
  logic [CNT_W+2:0] acc_q, acc_d;

  // Baseline plus threshold, clamped to the largest count value.
  function automatic logic [CNT_W-1:0] sat_thresh(input logic [CNT_W-1:0] base);
    logic [CNT_W:0] sum;
    sum = {1'b0, base} + (CNT_W+1)'(THRESHOLD);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  assign raw    = count_q > sat_thresh(acc_q[CNT_W+2:CAL_SHIFT]);
  assign deb_en = eval_en & ~cal_active;
`else
  assign raw    = count_q > THRESHOLD_C;
  assign deb_en = eval_en;
`endif

  always_comb begin
    sync_d    = {sync_q[0], pad_in};
    count_d   = count_q;
    done_d    = done_q;
    deb_d     = deb_q;
    touched_d = touched_q;
`ifdef CAP_SENSE_BASELINE_EN
    acc_d     = acc_q;
    if (eval_en && cal_active) acc_d = acc_q + {3'b000, count_q};
`endif

    // Charge counter: freezes once the pad reads high, saturates at TIMEOUT.
    if (clr_charge) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (charge_en && !done_q) begin
      if (sync_q[1])                done_d  = 1'b1;
      else if (count_q != TIMEOUT_C) count_d = count_q + CNT_W'(1);
    end

    // Debounce: only a run of consecutive disagreeing scans flips touched.
    if (deb_en) begin
      if (raw == touched_q) begin
        deb_d = '0;
      end else if (deb_q == DEB_LAST) begin
        deb_d     = '0;
        touched_d = ~touched_q;
      end else begin
        deb_d = deb_q + DEB_W'(1);
      end
    end
  end

  // Synchronizer flops carry no state worth resetting.
  always_ff @(posedge clock) sync_q <= sync_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q   <= '0;
      done_q    <= 1'b0;
      deb_q     <= '0;
      touched_q <= 1'b0;
`ifdef CAP_SENSE_BASELINE_EN
      acc_q     <= '0;
`endif
    end else begin
      count_q   <= count_d;
      done_q    <= done_d;
      deb_q     <= deb_d;
      touched_q <= touched_d;
`ifdef CAP_SENSE_BASELINE_EN
      acc_q     <= acc_d;
`endif
    end
  end

  assign done_nxt     = done_d;
  assign touched      = touched_q;
  assign touched_rise = touched_d & ~touched_q;

endmodule

// File: rtl/cap_sense_scanner.sv
// cap_sense_scanner: scans all capacitive mole pads in parallel.
//   Runs the DISCHARGE -> CHARGE -> EVAL cycle on the shared drive pin,
//   collects per-pad debounced touch state and keeps sticky touch events
//   for the processor's memory-mapped I/O.
// Optional build macro: CAP_SENSE_BASELINE_EN enables an 8-scan calibration
//   after reset and baseline-relative thresholds.
// Ports:
//   clock                  : system clock
//   reset                  : synchronous, active-high reset
//   enable                 : run continuous scans while high
//   capacitive_sensors_in  : raw asynchronous pad inputs
//   capacitive_sensors_out : shared drive pin (high during CHARGE)
//   events_clear           : one-cycle clear mask for touch_events
//   touched                : debounced touch state
//   touch_events           : sticky, set on touched rising edge
//   scan_done              : one-cycle pulse at the end of each scan
module cap_sense_scanner
  import cap_sense_pkg::*;
#(
  parameter int N_SENSORS        = N_SENSORS_DEF,
  parameter int CNT_W            = CNT_W_DEF,
  parameter int DISCHARGE_CYCLES = 1000,
  parameter int TIMEOUT          = 4095,
  parameter int THRESHOLD        = 400,
  parameter int DEBOUNCE_SCANS   = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N_SENSORS-1:0] capacitive_sensors_in,
  output logic                 capacitive_sensors_out,
  input  logic [N_SENSORS-1:0] events_clear,
  output logic [N_SENSORS-1:0] touched,
  output logic [N_SENSORS-1:0] touch_events,
  output logic                 scan_done
);

  localparam logic [CNT_W-1:0] DIS_LAST = CNT_W'(DISCHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     timer_q, timer_d;
  logic                 drive_q, drive_d;
  logic                 scan_done_q, scan_done_d;
  logic [N_SENSORS-1:0] events_q, events_d;
  logic                 clr_charge;
  logic                 charge_en;
  logic                 eval_en;
  logic [N_SENSORS-1:0] done_nxt;
  logic [N_SENSORS-1:0] touched_rise;

`ifdef CAP_SENSE_BASELINE_EN
  logic [3:0] cal_cnt_q, cal_cnt_d;
  logic       cal_active;

  assign cal_active = (cal_cnt_q != 4'(CAL_SCANS));
  assign cal_cnt_d  = (eval_en && cal_active) ? cal_cnt_q + 4'd1 : cal_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) cal_cnt_q <= '0;
    else       cal_cnt_q <= cal_cnt_d;
  end
`endif

  assign charge_en = (state_q == ST_CHARGE);
  assign eval_en   = (state_q == ST_EVAL);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    clr_charge = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_DISCHARGE;
          timer_d = '0;
        end
      end
      ST_DISCHARGE: begin
        if (timer_q == DIS_LAST) begin
          state_d    = ST_CHARGE;
          timer_d    = '0;
          clr_charge = 1'b1;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      ST_CHARGE: begin
        timer_d = timer_q + CNT_W'(1);
        // done_nxt includes pads finishing this cycle, so the phase ends
        // on the same cycle the last pad is seen high.
        if ((&done_nxt) || (timer_q == TO_LAST)) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        state_d = enable ? ST_DISCHARGE : ST_IDLE;
        timer_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    drive_d     = (state_d == ST_CHARGE);
    scan_done_d = eval_en;
    // A new rising edge wins over a simultaneous clear.
    events_d    = (events_q & ~events_clear) | touched_rise;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      drive_q     <= 1'b0;
      scan_done_q <= 1'b0;
      events_q    <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      drive_q     <= drive_d;
      scan_done_q <= scan_done_d;
      events_q    <= events_d;
    end
  end

  for (genvar i = 0; i < N_SENSORS; i++) begin : g_ch
    cap_sense_channel #(
      .CNT_W          (CNT_W),
      .TIMEOUT        (TIMEOUT),
      .THRESHOLD      (THRESHOLD),
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_ch (
      .clock        (clock),
      .reset        (reset),
      .pad_in       (capacitive_sensors_in[i]),
      .clr_charge   (clr_charge),
      .charge_en    (charge_en),
      .eval_en      (eval_en),
`ifdef CAP_SENSE_BASELINE_EN
      .cal_active   (cal_active),
`endif
      .done_nxt     (done_nxt[i]),
      .touched      (touched[i]),
      .touched_rise (touched_rise[i])
    );
  end

  assign capacitive_sensors_out = drive_q;
  assign touch_events           = events_q;
  assign scan_done              = scan_done_q;

endmodule

// File: tb/tb_cap_sense_scanner.sv
// tb_cap_sense_scanner: scoreboard bench for cap_sense_scanner.
//   Stimulus sets per-pad rise delays for each scan and pushes the expected
//   touched / touch_events / charge length; a monitor pops on scan_done.
module tb_cap_sense_scanner;

  localparam int N   = 9;
  localparam int DIS = 4;
  localparam int TO  = 100;
  localparam int TH  = 20;
  localparam int DEB = 2;
  localparam int NEVER = 1000;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic [N-1:0] sens_in;
  logic         drive;
  logic [N-1:0] events_clear = '0;
  logic [N-1:0] touched;
  logic [N-1:0] touch_events;
  logic         scan_done;

  always #5 clock = ~clock;

  cap_sense_scanner #(
    .N_SENSORS        (N),
    .CNT_W            (16),
    .DISCHARGE_CYCLES (DIS),
    .TIMEOUT          (TO),
    .THRESHOLD        (TH),
    .DEBOUNCE_SCANS   (DEB)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .enable                 (enable),
    .capacitive_sensors_in  (sens_in),
    .capacitive_sensors_out (drive),
    .events_clear           (events_clear),
    .touched                (touched),
    .touch_events           (touch_events),
    .scan_done              (scan_done)
  );

  typedef struct {
    int           id;
    logic [N-1:0] t;
    logic [N-1:0] e;
    int           charge;
    bit           chk_per;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   dly[N] = '{default: 5};
  int   scan_id = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // Pad model: pad i reads high once the drive has been high for more than
  // dly[i] cycles, and drops with the drive.
  initial begin
    int hi;
    hi = 0;
    sens_in = '0;
    forever begin
      @(posedge clock);
      #1;
      if (drive) hi++;
      else       hi = 0;
      for (int i = 0; i < N; i++) sens_in[i] = (hi > dly[i]);
    end
  end

  // Monitor: counts drive-high cycles and scan period, checks on scan_done.
  initial begin
    int   cyc, hi, last;
    exp_t e;
    cyc = 0; hi = 0; last = -1;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        hi = 0;
        last = -1;
      end else begin
        if (drive) hi++;
        if (scan_done) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_scan_done: got a pulse at cycle %0d, expected none", cyc);
          end else begin
            e = q.pop_front();
            check($sformatf("scan%0d_touched", e.id), 32'(touched), 32'(e.t));
            check($sformatf("scan%0d_events", e.id), 32'(touch_events), 32'(e.e));
            check($sformatf("scan%0d_charge_len", e.id), hi, e.charge);
            if (e.chk_per && last >= 0)
              check($sformatf("scan%0d_period", e.id), cyc - last, DIS + e.charge + 1);
          end
          last = cyc;
          hi = 0;
        end
      end
    end
  end

  task automatic set_dly(input int d3, input int d8);
    for (int i = 0; i < N; i++) dly[i] = 5;
    dly[3] = d3;
    dly[8] = d8;
  endtask

  task automatic set_scan(input int d3, input int d8, input logic [N-1:0] t,
                          input logic [N-1:0] e, input int charge, input bit per);
    exp_t x;
    set_dly(d3, d8);
    scan_id++;
    x.id = scan_id; x.t = t; x.e = e; x.charge = charge; x.chk_per = per;
    q.push_back(x);
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(posedge clock);
      #1;
      got = scan_done;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL wait_scan_done: no pulse within 400 cycles, expected one");
    end
  endtask

  task automatic wait_drive(input logic lvl);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(posedge clock);
      #1;
      got = (drive == lvl);
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL wait_drive: drive never reached %0d within 400 cycles", lvl);
    end
  endtask

  task automatic idle_window(input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clock);
      #1;
      if (drive || scan_done) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_drive", 32'(drive), 0);
    check("rst_touched", 32'(touched), 0);
    check("rst_events", 32'(touch_events), 0);
    check("rst_scan_done", 32'(scan_done), 0);
    reset = 1'b0;
    idle_window("idle_enable_low");

    // All pads fast: count 7, charge 8 cycles, nothing touched
    set_scan(5, 5, 9'h000, 9'h000, 8, 1'b0);
    enable = 1'b1;
    wait_done();
    for (int s = 0; s < 4; s++) begin
      set_scan(5, 5, 9'h000, 9'h000, 8, 1'b1);
      wait_done();
    end

    // Pad 3 slow for two scans: touched only after the second
    set_scan(50, 5, 9'h000, 9'h000, 53, 1'b1); wait_done();
    set_scan(50, 5, 9'h008, 9'h008, 53, 1'b1); wait_done();

    // Pad 8 never rises: timeout at 100 cycles, touched after two scans
    set_scan(50, NEVER, 9'h008, 9'h008, 100, 1'b1); wait_done();
    set_scan(50, NEVER, 9'h108, 9'h108, 100, 1'b1); wait_done();

    // Single short scans on pad 3 separated by a long one do not release it
    set_scan(5,  NEVER, 9'h108, 9'h108, 100, 1'b1); wait_done();
    set_scan(50, NEVER, 9'h108, 9'h108, 100, 1'b1); wait_done();
    set_scan(5,  NEVER, 9'h108, 9'h108, 100, 1'b1); wait_done();
    // Second consecutive short scan releases pad 3; its event stays set
    set_scan(5,  NEVER, 9'h100, 9'h108, 100, 1'b1); wait_done();

    // Plain clear of event 3
    events_clear = 9'h008;
    @(posedge clock);
    #1;
    events_clear = '0;
    check("ev_clear_only", 32'(touch_events), 32'h100);
    check("ev_clear_touched", 32'(touched), 32'h100);

    // Re-touch pad 3 with a clear landing on the rising-edge cycle
    set_scan(50, NEVER, 9'h100, 9'h100, 100, 1'b1); wait_done();
    set_scan(50, NEVER, 9'h108, 9'h108, 100, 1'b1);
    wait_drive(1'b1);
    wait_drive(1'b0);
    events_clear = 9'h008;
    wait_done();
    events_clear = '0;

    // Enable dropped mid-charge: scan completes then idles
    set_scan(50, NEVER, 9'h108, 9'h108, 100, 1'b1);
    wait_drive(1'b1);
    repeat (10) @(posedge clock);
    #1;
    enable = 1'b0;
    wait_done();
    idle_window("idle_after_disable");

    // Reset mid-charge discards the scan
    set_dly(50, 5);
    enable = 1'b1;
    wait_drive(1'b1);
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    enable = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_drive", 32'(drive), 0);
    check("midrst_touched", 32'(touched), 0);
    check("midrst_events", 32'(touch_events), 0);
    check("midrst_scan_done", 32'(scan_done), 0);
    reset = 1'b0;

    // Scanning resumes cleanly after reset
    set_scan(5, 5, 9'h000, 9'h000, 8, 1'b0);
    enable = 1'b1;
    wait_done();
    set_scan(50, 5, 9'h000, 9'h000, 53, 1'b1);
    wait_done();
    enable = 1'b0;
    repeat (30) @(posedge clock);
    #1;
    check("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
